// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the inst/data memory port arbiter.
package mem_port_arbiter_pkg;

  // FSM state encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Owner encodings.
  typedef logic owner_t;
  localparam owner_t OWNER_IF = 1'b0;
  localparam owner_t OWNER_D  = 1'b1;

  // Arbitration modes.
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  // Generic enable/disable levels.
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Wait counter width; covers LATENCY up to 7.
  localparam int CNT_W = 3;

  // The port that did not own the previous access.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_IF) ? OWNER_D : OWNER_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Owner selection between the fetch and data ports.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int RR_MODE = RR_FIXED
) (
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  owner_t last_owner_i,
  output logic   grant_o,
  output owner_t owner_o
);

  // Pick an owner: fixed priority favours data, round-robin alternates on conflict.
  always_comb begin
    grant_o = if_req_i | d_req_i;
    owner_o = OWNER_IF;
    if (RR_MODE == RR_ROUND) begin
      if (if_req_i && d_req_i) begin
        owner_o = other_owner(last_owner_i);
      end else if (d_req_i) begin
        owner_o = OWNER_D;
      end
    end else if (d_req_i) begin
      owner_o = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and load/store accesses onto one single-port memory.
//
// state    | meaning
// ST_IDLE  | no access in flight; sample requests and latch the winner into mem_*
// ST_ISSUE | mem_ce_o high for this single cycle
// ST_WAIT  | count memory latency; capture read data when cnt reaches LATENCY
// ST_RESP  | owner's ack pulses; requests are not resampled (req may be stale)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int RR_MODE = RR_FIXED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                stall_if_o,
  output logic                stall_mem_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  owner_t             owner_q, owner_d;
  owner_t             last_owner_q, last_owner_d;
  logic               mem_ce_q, mem_ce_d;
  logic               mem_we_q, mem_we_d;
  logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               if_ack_q, if_ack_d;
  logic               d_ack_q, d_ack_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

  logic   grant;
  owner_t pick_owner;

  mem_arb_pick #(
    .RR_MODE (RR_MODE)
  ) u_pick (
    .if_req_i     (if_req_i),
    .d_req_i      (d_req_i),
    .last_owner_i (last_owner_q),
    .grant_o      (grant),
    .owner_o      (pick_owner)
  );

  // Next-state logic for the access sequencer and its registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_ce_d     = DISABLE;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = DISABLE;
    d_ack_d      = DISABLE;
    if_rdata_d   = '0;
    d_rdata_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d  = pick_owner;
          mem_ce_d = ENABLE;
          if (pick_owner == OWNER_D) begin
            mem_we_d    = d_we_i;
            mem_sel_d   = d_sel_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            mem_we_d    = DISABLE;
            mem_sel_d   = '1;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == LAT_C) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_D) begin
            d_ack_d   = ENABLE;
            // Writes complete with zero load data.
            d_rdata_d = mem_we_q ? '0 : mem_rdata_i;
          end else begin
            if_ack_d   = ENABLE;
            if_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_owner_d = owner_q;
        cnt_d        = '0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWNER_IF;
      last_owner_q <= OWNER_IF;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  // Stall lifts in the ack cycle so the pipeline advances together with the data.
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_mem_o = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (fixed L=1, RR L=1, RR L=3),
// a shared behavioural memory and an in-order completion scoreboard.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        if_ack    [3];
  logic [31:0] if_rdata  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [3:0]  d_sel     [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic        d_ack     [3];
  logic [31:0] d_rdata   [3];
  logic        stall_if  [3];
  logic        stall_mem [3];
  logic        mem_ce    [3];
  logic        mem_we    [3];
  logic [3:0]  mem_sel   [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  bit   [31:0] mem_arr [256];
  bit          wflag   [256];
  bit   [31:0] pipe    [3][8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          inst;
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int RRM = (g == 0) ? 0 : 1;
    mem_port_arbiter #(
      .ADDR_W (32), .DATA_W (32), .LATENCY (LAT), .RR_MODE (RRM)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req[g]),
      .if_addr_i   (if_addr[g]),
      .if_ack_o    (if_ack[g]),
      .if_rdata_o  (if_rdata[g]),
      .d_req_i     (d_req[g]),
      .d_we_i      (d_we[g]),
      .d_sel_i     (d_sel[g]),
      .d_addr_i    (d_addr[g]),
      .d_wdata_i   (d_wdata[g]),
      .d_ack_o     (d_ack[g]),
      .d_rdata_o   (d_rdata[g]),
      .stall_if_o  (stall_if[g]),
      .stall_mem_o (stall_mem[g]),
      .mem_ce_o    (mem_ce[g]),
      .mem_we_o    (mem_we[g]),
      .mem_sel_o   (mem_sel[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g])
    );
    assign mem_rdata[g] = pipe[g][LAT-1];
  end

  // Power-up contents of a word that has never been written.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h10) return 32'h3401_1100;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: samples the strobe, read data emerges LAT cycles later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      for (int s = 7; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
      pipe[k][0] <= 32'h0;
      if (mem_ce[k] === 1'b1) begin
        automatic int          idx = int'(mem_addr[k][9:2]);
        automatic logic [31:0] cur = wflag[idx] ? mem_arr[idx]
                                     : mem_init({mem_addr[k][31:2], 2'b00});
        if (mem_we[k]) begin
          for (int b = 0; b < 4; b++)
            if (mem_sel[k][b]) cur[8*b +: 8] = mem_wdata[k][8*b +: 8];
          mem_arr[idx] <= cur;
          wflag[idx]   <= 1'b1;
        end else begin
          pipe[k][0] <= cur;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int k, input bit is_d, input logic [31:0] data);
    exp_t e;
    e.inst = k; e.is_d = is_d; e.data = data;
    sb_q.push_back(e);
  endtask

  // Completion monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (if_ack[k] === 1'b1 || d_ack[k] === 1'b1) begin
        chk("ack_exclusive", {if_ack[k], d_ack[k]} == 2'b11, 1'b0);
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_ack", 1, 0);
        end else begin
          automatic exp_t e = sb_q.pop_front();
          chk("sb_inst", k, e.inst);
          chk("sb_port", d_ack[k], e.is_d);
          chk("sb_rdata", d_ack[k] ? d_rdata[k] : if_rdata[k], e.data);
          chk("nonowner_rdata", d_ack[k] ? if_rdata[k] : d_rdata[k], 0);
        end
      end
    end
  end

  // One access on instance k, checking issue timing, stall and ack cycle.
  task automatic single(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel, input logic [31:0] exp);
    automatic int lat = (k == 2) ? 3 : 1;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; d_sel[k] = sel;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    sb_push(k, is_d, exp);
    #1;
    chk("stall_req_cycle", is_d ? stall_mem[k] : stall_if[k], 1'b1);
    for (int c = 1; c <= 2 + lat; c++) begin
      tick();
      chk("mem_ce_timing", mem_ce[k], c == 1);
      if (c == 1) begin
        chk("mem_addr", mem_addr[k], addr);
        chk("mem_we", mem_we[k], is_d ? we : 1'b0);
        chk("mem_sel", mem_sel[k], is_d ? sel : 4'hF);
        chk("mem_wdata", mem_wdata[k], is_d ? wdata : 32'h0);
      end
      chk("ack_timing", is_d ? d_ack[k] : if_ack[k], c == 2 + lat);
      chk("stall_pending", is_d ? stall_mem[k] : stall_if[k], c < 2 + lat);
    end
    if (is_d) d_req[k] = 1'b0; else if_req[k] = 1'b0;
    tick();
  endtask

  // Both ports held high: order comes from the scoreboard, spacing checked here.
  task automatic rr_run(input int k);
    automatic int lat = (k == 2) ? 3 : 1;
    automatic int acks = 0;
    automatic int last_cyc = -1;
    if_req[k] = 1'b1; if_addr[k] = 32'h20;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_sel[k] = 4'hF; d_addr[k] = 32'h40; d_wdata[k] = 32'h0;
    for (int i = 0; i < 4; i++)
      sb_push(k, (i % 2) == 0, ((i % 2) == 0) ? mem_init(32'h40) : mem_init(32'h20));
    for (int c = 0; c < 60 && acks < 4; c++) begin
      tick();
      if (if_ack[k] === 1'b1 || d_ack[k] === 1'b1) begin
        if (last_cyc >= 0) chk("rr_ack_spacing", cyc - last_cyc, lat + 3);
        last_cyc = cyc;
        acks++;
      end
    end
    chk("rr_ack_count", acks, 4);
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
      d_sel[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_mem_ce", mem_ce[k], 0);
      chk("rst_if_ack", if_ack[k], 0);
      chk("rst_d_ack", d_ack[k], 0);
      chk("rst_mem_addr", mem_addr[k], 0);
      chk("rst_mem_sel", mem_sel[k], 0);
      chk("rst_if_rdata", if_rdata[k], 0);
      chk("rst_stall_if", stall_if[k], 0);
    end
    tick();

    // Reset asserted for 3 cycles while the fetch sits in WAIT.
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    tick();
    chk("abort_issue_ce", mem_ce[0], 1);
    tick();
    rst = 1'b1; if_req[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_no_ack", if_ack[0], 0);
      chk("abort_ce_low", mem_ce[0], 0);
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("post_abort_no_ack", if_ack[0], 0);
      chk("post_abort_ce_low", mem_ce[0], 0);
    end

    // Fresh fetch after the abort.
    single(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h3401_1100);

    // Write then read back; a write acks with zero data.
    single(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0);
    single(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF);

    // Partial byte-enable write merges with existing contents.
    single(0, 1'b1, 1'b1, 32'h104, 32'hAABB_CCDD, 4'b0011, 32'h0);
    single(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, {mem_init(32'h104)[31:16], 16'hCCDD});

    // Fixed-priority conflict: data first, fetch LATENCY+3 cycles later.
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_sel[0] = 4'hF; d_addr[0] = 32'h100;
    sb_push(0, 1'b1, 32'hDEAD_BEEF);
    sb_push(0, 1'b0, 32'h3401_1100);
    #1;
    chk("conflict_stall_if_c0", stall_if[0], 1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("conflict_d_ack", d_ack[0], c == 3);
      chk("conflict_if_ack", if_ack[0], c == 7);
      if (c < 7) chk("conflict_stall_if", stall_if[0], 1);
      if (c == 3) d_req[0] = 1'b0;
      if (c == 7) if_req[0] = 1'b0;
    end

    // Fetch request dropped during ISSUE still completes once.
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    sb_push(0, 1'b0, 32'h3401_1100);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("drop_mem_ce", mem_ce[0], c == 1);
      chk("drop_if_ack", if_ack[0], c == 3);
      if (c == 1) if_req[0] = 1'b0;
    end

    // Round-robin with LATENCY=1 and LATENCY=3.
    rr_run(1);
    rr_run(2);

    // Single fetch on the long-latency instance.
    single(2, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h3401_1100);

    repeat (3) tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
